// File: rtl/bullet_collision_scanner.sv
// Per-frame bullet/player box collision sweep over the bullet descriptor table.
// Results are published with a one-cycle done pulse and held until the next one.
module bullet_collision_scanner #(
  parameter int NUM_SLOTS    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] player_pos,
  input  logic [15:0] player_size,
  output logic [3:0]  bullet_index,
  input  logic [15:0] bullet_position,
  input  logic [15:0] bullet_size,
  input  logic [2:0]  bullet_color,
  input  logic        bullet_render,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [3:0]  hit_index,
  output logic [2:0]  hit_color,
  output logic [3:0]  hit_count
);

  // Handshake: start is sampled only while idle (busy=0, which includes the
  // done cycle); done is a one-cycle pulse and the hit_* outputs stay valid
  // from that cycle until the next done.

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NUM_SLOTS - 1);

  state_t state, next_state;

  logic [15:0] p_pos, p_size;
  logic        acc_hit;
  logic [3:0]  acc_index;
  logic [2:0]  acc_color;
  logic [3:0]  acc_count;

  logic [READ_LATENCY-1:0]      tag_valid;
  logic [READ_LATENCY-1:0][3:0] tag_slot;

  logic       accept;
  logic       push_valid;
  logic [3:0] push_slot;
  logic       consume;
  logic       slot_hit;

  // A zero extent on either box never overlaps; sums are 9 bits so they never wrap.
  function automatic logic span_overlap(input logic [7:0] a, input logic [7:0] aw,
                                        input logic [7:0] b, input logic [7:0] bw);
    return (aw != 8'd0) && (bw != 8'd0) &&
           ({1'b0, a} < ({1'b0, b} + {1'b0, bw})) &&
           ({1'b0, b} < ({1'b0, a} + {1'b0, aw}));
  endfunction

  assign consume  = tag_valid[READ_LATENCY-1];
  assign slot_hit = bullet_render &&
                    span_overlap(bullet_position[15:8], bullet_size[15:8],
                                 p_pos[15:8], p_size[15:8]) &&
                    span_overlap(bullet_position[7:0], bullet_size[7:0],
                                 p_pos[7:0], p_size[7:0]);

  assign busy = (state != IDLE);

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    push_valid = 1'b0;
    push_slot  = 4'd0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          push_valid = 1'b1;
          push_slot  = 4'd0;
          next_state = (LAST == 4'd0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        push_valid = 1'b1;
        push_slot  = 4'(bullet_index + 4'd1);
        if (bullet_index == 4'(LAST - 4'd1)) next_state = DRAIN;
      end
      DRAIN: begin
        if (consume && (tag_slot[READ_LATENCY-1] == LAST)) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Issue side: slot address plus a tag that travels alongside the table read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bullet_index <= 4'd0;
      p_pos        <= 16'd0;
      p_size       <= 16'd0;
      tag_valid    <= '0;
      tag_slot     <= '0;
    end else begin
      if (accept) begin
        bullet_index <= 4'd0;
        p_pos        <= player_pos;
        p_size       <= player_size;
      end else if (state == ISSUE) begin
        bullet_index <= push_slot;
      end
      for (int k = READ_LATENCY - 1; k > 0; k--) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_slot[k]  <= tag_slot[k-1];
      end
      tag_valid[0] <= push_valid;
      tag_slot[0]  <= push_slot;
    end
  end

  // Accumulate while the sweep runs; the first hit in slot order owns index/color.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hit   <= 1'b0;
      acc_index <= 4'd0;
      acc_color <= 3'd0;
      acc_count <= 4'd0;
    end else if (accept) begin
      acc_hit   <= 1'b0;
      acc_index <= 4'd0;
      acc_color <= 3'd0;
      acc_count <= 4'd0;
    end else if (consume && slot_hit) begin
      if (!acc_hit) begin
        acc_hit   <= 1'b1;
        acc_index <= tag_slot[READ_LATENCY-1];
        acc_color <= bullet_color;
      end
      if (acc_count != 4'd15) acc_count <= acc_count + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_index <= 4'd0;
      hit_color <= 3'd0;
      hit_count <= 4'd0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        hit       <= acc_hit;
        hit_index <= acc_index;
        hit_color <= acc_color;
        hit_count <= acc_count;
      end
    end
  end

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Directed bench for bullet_collision_scanner: table model with registered read,
// expected results queued at start and checked by a done-driven monitor.
module tb_bullet_collision_scanner;

  localparam int NUM_SLOTS    = 8;
  localparam int READ_LATENCY = 2;
  localparam int SWEEP        = NUM_SLOTS + READ_LATENCY;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] player_pos;
  logic [15:0] player_size;
  logic [3:0]  bullet_index;
  logic [15:0] bullet_position;
  logic [15:0] bullet_size;
  logic [2:0]  bullet_color;
  logic        bullet_render;
  logic        busy;
  logic        done;
  logic        hit;
  logic [3:0]  hit_index;
  logic [2:0]  hit_color;
  logic [3:0]  hit_count;

  bullet_collision_scanner #(
    .NUM_SLOTS(NUM_SLOTS),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .player_pos(player_pos),
    .player_size(player_size),
    .bullet_index(bullet_index),
    .bullet_position(bullet_position),
    .bullet_size(bullet_size),
    .bullet_color(bullet_color),
    .bullet_render(bullet_render),
    .busy(busy),
    .done(done),
    .hit(hit),
    .hit_index(hit_index),
    .hit_color(hit_color),
    .hit_count(hit_count)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bullet table model ----------------
  // The DUT registers bullet_index; one more register here makes slot i's data
  // available READ_LATENCY edges after the edge that drove index i.
  logic [15:0] t_pos    [16];
  logic [15:0] t_size   [16];
  logic [2:0]  t_color  [16];
  logic        t_render [16];
  logic [3:0]  rd_idx;

  always @(posedge clk) rd_idx <= bullet_index;

  assign bullet_position = t_pos[rd_idx];
  assign bullet_size     = t_size[rd_idx];
  assign bullet_color    = t_color[rd_idx];
  assign bullet_render   = t_render[rd_idx];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [11:0] mon_exp;
  int          mon_cyc;

  function automatic logic [11:0] pack(input logic h, input logic [3:0] i,
                                       input logic [2:0] c, input logic [3:0] n);
    return {h, i, c, n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("result", {20'd0, hit, hit_index, hit_color, hit_count}, {20'd0, mon_exp});
        check("done_cycle", mon_cyc, cyc);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_table();
    for (int i = 0; i < 16; i++) begin
      t_pos[i]    = 16'd0;
      t_size[i]   = 16'd0;
      t_color[i]  = 3'd0;
      t_render[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int i, input logic [15:0] p, input logic [15:0] s,
                          input logic [2:0] c, input logic r);
    t_pos[i]    = p;
    t_size[i]   = s;
    t_color[i]  = c;
    t_render[i] = r;
  endtask

  // Called at a negedge; start is accepted on the following posedge (edge S).
  task automatic start_sweep(input logic [15:0] pp, input logic [15:0] ps,
                             input logic [11:0] e, input int hold);
    player_pos  = pp;
    player_size = ps;
    start       = 1'b1;
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("index_after_start", {28'd0, bullet_index}, 32'd0);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + SWEEP);
    player_pos  = ~pp;
    player_size = ~ps;
    repeat (hold - 1) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * SWEEP) begin
      @(negedge clk);
      n++;
    end
    check("sweep_completed", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    check({name, "_result"}, {20'd0, hit, hit_index, hit_color, hit_count}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_index"}, {28'd0, bullet_index}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset       = 1'b1;
    start       = 1'b0;
    player_pos  = 16'd0;
    player_size = 16'd0;
    clear_table();
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_idle("idle");

    // single hit in slot 1
    clear_table();
    set_slot(1, 16'h55AA, 16'hF00F, 3'd1, 1'b1);
    start_sweep(16'h60B0, 16'h0808, pack(1'b1, 4'd1, 3'd1, 4'd1), 1);
    wait_idle();
    check("result_held", {20'd0, hit, hit_index, hit_color, hit_count},
          {20'd0, pack(1'b1, 4'd1, 3'd1, 4'd1)});

    // right edge of bullet exactly touches player left edge
    clear_table();
    set_slot(1, 16'h55AA, 16'h0F0F, 3'd1, 1'b1);
    start_sweep(16'h64B0, 16'h0808, pack(1'b0, 4'd0, 3'd0, 4'd0), 1);
    wait_idle();

    // several hits, one overlapping slot not rendered, one rendered miss
    clear_table();
    set_slot(0, 16'h1010, 16'h0404, 3'd7, 1'b1);
    set_slot(2, 16'h4444, 16'h0404, 3'd3, 1'b1);
    set_slot(3, 16'h4444, 16'h0404, 3'd5, 1'b0);
    set_slot(5, 16'h4444, 16'h0404, 3'd4, 1'b1);
    set_slot(7, 16'h4444, 16'h0404, 3'd6, 1'b1);
    start_sweep(16'h4040, 16'h1010, pack(1'b1, 4'd2, 3'd3, 4'd3), 1);
    wait_idle();

    // bullet x+xsize exceeds 255: no wrap, so no hit on a player at x=2
    clear_table();
    set_slot(0, 16'hF810, 16'h1008, 3'd7, 1'b1);
    start_sweep(16'h0212, 16'h0404, pack(1'b0, 4'd0, 3'd0, 4'd0), 1);
    wait_idle();

    // both boxes near 255: true overlap that an 8-bit sum would miss
    clear_table();
    set_slot(6, 16'hF8F8, 16'h1010, 3'd2, 1'b1);
    start_sweep(16'hFAFA, 16'h0404, pack(1'b1, 4'd6, 3'd2, 4'd1), 1);
    wait_idle();

    // zero bullet width never hits; later normal slot does
    clear_table();
    set_slot(3, 16'h4040, 16'h0010, 3'd5, 1'b1);
    set_slot(4, 16'h4040, 16'h0808, 3'd6, 1'b1);
    start_sweep(16'h3838, 16'h1010, pack(1'b1, 4'd4, 3'd6, 4'd1), 1);
    wait_idle();

    // zero player width never hits
    clear_table();
    set_slot(4, 16'h4040, 16'h0808, 3'd6, 1'b1);
    start_sweep(16'h4444, 16'h0010, pack(1'b0, 4'd0, 3'd0, 4'd0), 1);
    wait_idle();

    // start held for 3 cycles: exactly one sweep
    clear_table();
    set_slot(5, 16'h4444, 16'h0404, 3'd4, 1'b1);
    start_sweep(16'h4040, 16'h1010, pack(1'b1, 4'd5, 3'd4, 4'd1), 3);
    wait_idle();
    repeat (15) @(negedge clk);

    // reset mid-sweep clears held results and aborts without done
    clear_table();
    set_slot(2, 16'h4444, 16'h0404, 3'd3, 1'b1);
    start_sweep(16'h4040, 16'h1010, pack(1'b1, 4'd2, 3'd3, 4'd1), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check_idle("after_abort");

    // back-to-back: second start in the done cycle
    clear_table();
    set_slot(1, 16'h55AA, 16'hF00F, 3'd1, 1'b1);
    start_sweep(16'h60B0, 16'h0808, pack(1'b1, 4'd1, 3'd1, 4'd1), 1);
    n = 0;
    while (!done && n < 3 * SWEEP) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    clear_table();
    set_slot(2, 16'h4444, 16'h0404, 3'd3, 1'b1);
    set_slot(7, 16'h4444, 16'h0404, 3'd6, 1'b1);
    start_sweep(16'h4040, 16'h1010, pack(1'b1, 4'd2, 3'd3, 4'd2), 1);
    check("b2b_held", {20'd0, hit, hit_index, hit_color, hit_count},
          {20'd0, pack(1'b1, 4'd1, 3'd1, 4'd1)});
    check("b2b_done_low", {31'd0, done}, 32'd0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
